// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the RV64I integer ALU: decodes ALU-class opcodes, reads operands
// from the register file and registers the operand/opcode bundle toward execute.

package alu_issue_pkg;
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluLui  = 4'd10,
    AluJal  = 4'd11
  } aluop_t;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic            ex_word32,
  output aluop_t          ex_aluop,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImmW = 7'b0011011;
  localparam logic [6:0] OpcOpW    = 7'b0111011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt6;
  logic [XLEN-1:0] shamt5;

  logic            fire;
  logic            legal;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  aluop_t          dec_op;
  logic            dec_w32;

  assign opcode   = if_inst[6:0];
  assign funct3   = if_inst[14:12];
  assign funct7   = if_inst[31:25];
  assign rd       = if_inst[11:7];
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  assign imm_i  = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign imm_u  = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, if_inst[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, if_inst[24:20]};

  assign if_ready = (!ex_valid || ex_ready) && !flush;
  assign fire     = if_valid && if_ready;

  always_comb begin
    legal   = 1'b1;
    dec_a   = '0;
    dec_b   = '0;
    dec_op  = AluAdd;
    dec_w32 = 1'b0;
    case (opcode)
      OpcLui: begin
        dec_op = AluLui;
        dec_b  = imm_u;
      end
      OpcAuipc: begin
        dec_a = if_pc;
        dec_b = imm_u;
      end
      OpcJal, OpcJalr: begin
        dec_op = AluJal;
        dec_a  = if_pc;
      end
      OpcOpImm: begin
        dec_a = rs1_data;
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_op = AluAdd;
          3'b010: dec_op = AluSlt;
          3'b011: dec_op = AluSltu;
          3'b100: dec_op = AluXor;
          3'b110: dec_op = AluOr;
          3'b111: dec_op = AluAnd;
          3'b001: begin
            dec_op = AluSll;
            dec_b  = shamt6;
            legal  = (if_inst[31:26] == 6'b000000);
          end
          default: begin  // 3'b101
            dec_op = if_inst[30] ? AluSra : AluSrl;
            dec_b  = shamt6;
            legal  = (if_inst[31] == 1'b0) && (if_inst[29:26] == 4'b0000);
          end
        endcase
      end
      OpcOp: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        // funct7 0x20 is only defined for SUB and SRA
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
          3'b000:  dec_op = if_inst[30] ? AluSub : AluAdd;
          3'b001:  dec_op = AluSll;
          3'b010:  dec_op = AluSlt;
          3'b011:  dec_op = AluSltu;
          3'b100:  dec_op = AluXor;
          3'b101:  dec_op = if_inst[30] ? AluSra : AluSrl;
          3'b110:  dec_op = AluOr;
          default: dec_op = AluAnd;
        endcase
      end
      OpcOpImmW: begin
        dec_a   = rs1_data;
        dec_w32 = 1'b1;
        case (funct3)
          3'b000: dec_b = imm_i;
          3'b001: begin
            dec_op = AluSll;
            dec_b  = shamt5;
            legal  = (funct7 == 7'h00);
          end
          3'b101: begin
            dec_op = if_inst[30] ? AluSra : AluSrl;
            dec_b  = shamt5;
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          default: legal = 1'b0;
        endcase
      end
      OpcOpW: begin
        dec_a   = rs1_data;
        dec_b   = rs2_data;
        dec_w32 = 1'b1;
        case (funct3)
          3'b000: begin
            dec_op = if_inst[30] ? AluSub : AluAdd;
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'b001: begin
            dec_op = AluSll;
            legal  = (funct7 == 7'h00);
          end
          3'b101: begin
            dec_op = if_inst[30] ? AluSra : AluSrl;
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_op  = AluAdd;
      dec_w32 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_word32  <= 1'b0;
      ex_aluop   <= AluAdd;
      ex_rd      <= '0;
      ex_wen     <= 1'b0;
      ex_pc      <= '0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (fire) begin
      ex_valid   <= 1'b1;
      ex_a       <= dec_a;
      ex_b       <= dec_b;
      ex_word32  <= dec_w32;
      ex_aluop   <= dec_op;
      ex_rd      <= rd;
      ex_wen     <= legal && (rd != 5'd0);
      ex_pc      <= if_pc;
      ex_illegal <= !legal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus stall, stream and flush sequences.

module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_a;
  logic [63:0] ex_b;
  logic        ex_word32;
  aluop_t      ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [63:0] ex_pc;
  logic        ex_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_word32  (ex_word32),
    .ex_aluop   (ex_aluop),
    .ex_rd      (ex_rd),
    .ex_wen     (ex_wen),
    .ex_pc      (ex_pc),
    .ex_illegal (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] a;
    logic [63:0] b;
    logic        w32;
    aluop_t      op;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } vec_t;

  localparam int NVec = 15;
  vec_t vecs [NVec];

  logic [31:0] stream [4];
  int          p;
  int          got;
  int          last_cyc;
  logic        fire_s;
  logic        have_held;
  logic [4:0]  held_rd;
  logic [63:0] held_b;

  initial begin
    vecs[0]  = '{32'h00500093, 64'h0,    64'h0,    64'h0,  64'h0,    64'h5,    1'b0, AluAdd,  5'd1,  1'b1, 1'b0};
    vecs[1]  = '{32'h402081B3, 64'h4,    64'd10,   64'd3,  64'd10,   64'd3,    1'b0, AluSub,  5'd3,  1'b1, 1'b0};
    vecs[2]  = '{32'h800002B7, 64'h8,    64'h77,   64'h88, 64'h0,    64'hFFFFFFFF80000000, 1'b0, AluLui, 5'd5, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFF3031B, 64'hC,    64'h123,  64'h0,  64'h123,  64'hFFFFFFFFFFFFFFFF, 1'b1, AluAdd, 5'd6, 1'b1, 1'b0};
    vecs[4]  = '{32'h43F3D393, 64'h10,   64'h8000000000000000, 64'h0, 64'h8000000000000000, 64'd63, 1'b0, AluSra, 5'd7, 1'b1, 1'b0};
    vecs[5]  = '{32'h00112023, 64'h14,   64'h55,   64'h66, 64'h0,    64'h0,    1'b0, AluAdd,  5'd0,  1'b0, 1'b1};
    vecs[6]  = '{32'h022081B3, 64'h18,   64'h55,   64'h66, 64'h0,    64'h0,    1'b0, AluAdd,  5'd3,  1'b0, 1'b1};
    vecs[7]  = '{32'h00000013, 64'h1C,   64'h0,    64'h0,  64'h0,    64'h0,    1'b0, AluAdd,  5'd0,  1'b0, 1'b0};
    vecs[8]  = '{32'h12345517, 64'h1000, 64'h0,    64'h0,  64'h1000, 64'h12345000, 1'b0, AluAdd, 5'd10, 1'b1, 1'b0};
    vecs[9]  = '{32'h008000EF, 64'h2000, 64'h99,   64'h0,  64'h2000, 64'h0,    1'b0, AluJal,  5'd1,  1'b1, 1'b0};
    vecs[10] = '{32'h0020923B, 64'h2004, 64'h1111, 64'h22, 64'h1111, 64'h22,   1'b1, AluSll,  5'd4,  1'b1, 1'b0};
    vecs[11] = '{32'h41F2D29B, 64'h2008, 64'hFFFF0000, 64'h0, 64'hFFFF0000, 64'd31, 1'b1, AluSra, 5'd5, 1'b1, 1'b0};
    vecs[12] = '{32'hFFF4C413, 64'h200C, 64'h0F0F, 64'h0,  64'h0F0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, AluXor, 5'd8, 1'b1, 1'b0};
    vecs[13] = '{32'h003130B3, 64'h2010, 64'd5,    64'd7,  64'd5,    64'd7,    1'b0, AluSltu, 5'd1,  1'b1, 1'b0};
    vecs[14] = '{32'h4020F1B3, 64'h2014, 64'd1,    64'd2,  64'h0,    64'h0,    1'b0, AluAdd,  5'd3,  1'b0, 1'b1};

    // Reset held while a valid instruction is presented
    rst      = 1'b1;
    flush    = 1'b0;
    if_valid = 1'b1;
    if_inst  = 32'h00500093;
    if_pc    = 64'h0;
    rs1_data = 64'h0;
    rs2_data = 64'h0;
    ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(ex_valid), 64'h0);
    chk("reset_a", ex_a, 64'h0);
    chk("reset_b", ex_b, 64'h0);
    chk("reset_aluop", 64'(ex_aluop), 64'h0);
    chk("reset_wen", 64'(ex_wen), 64'h0);
    @(negedge clk);
    rst      = 1'b0;
    if_valid = 1'b0;

    // Decode table, one instruction per cycle
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      if_valid = 1'b1;
      if_inst  = vecs[i].inst;
      if_pc    = vecs[i].pc;
      rs1_data = vecs[i].rs1;
      rs2_data = vecs[i].rs2;
      ex_ready = 1'b1;
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'h1);
      chk($sformatf("v%0d_a", i), ex_a, vecs[i].a);
      chk($sformatf("v%0d_b", i), ex_b, vecs[i].b);
      chk($sformatf("v%0d_w32", i), 64'(ex_word32), 64'(vecs[i].w32));
      chk($sformatf("v%0d_op", i), 64'(ex_aluop), 64'(vecs[i].op));
      chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_wen", i), 64'(ex_wen), 64'(vecs[i].wen));
      chk($sformatf("v%0d_ill", i), 64'(ex_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
    end

    // Register address outputs are combinational from the instruction word
    @(negedge clk);
    if_inst = 32'h402081B3;
    #1;
    chk("rs1_addr", 64'(rs1_addr), 64'd1);
    chk("rs2_addr", 64'(rs2_addr), 64'd2);
    @(posedge clk);
    #1;
    chk("drain_valid", 64'(ex_valid), 64'h0);

    // Stream of 4 with a 3-cycle stall; ADDI xk,x0,k so rd and b identify each one
    for (int k = 0; k < 4; k++) stream[k] = ((k + 1) << 20) | ((k + 1) << 7) | 32'h13;
    p         = 0;
    got       = 0;
    last_cyc  = -1;
    have_held = 1'b0;
    held_rd   = '0;
    held_b    = '0;
    rs1_data  = 64'h0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      ex_ready = !(cyc >= 2 && cyc <= 4);
      if_valid = (p < 4);
      if_inst  = (p < 4) ? stream[p] : 32'h0;
      #1;
      if (ex_valid && ex_ready) begin
        chk($sformatf("stream_rd%0d", got), 64'(ex_rd), 64'(got + 1));
        chk($sformatf("stream_b%0d", got), ex_b, 64'(got + 1));
        got++;
        last_cyc = cyc;
      end
      if (ex_valid && !ex_ready) begin
        chk($sformatf("stall_if_ready_c%0d", cyc), 64'(if_ready), 64'h0);
        if (have_held) begin
          chk($sformatf("stall_rd_c%0d", cyc), 64'(ex_rd), 64'(held_rd));
          chk($sformatf("stall_b_c%0d", cyc), ex_b, held_b);
        end
        have_held = 1'b1;
        held_rd   = ex_rd;
        held_b    = ex_b;
      end
      fire_s = if_valid && if_ready;
      @(posedge clk);
      if (fire_s) p++;
    end
    chk("stream_count", 64'(got), 64'd4);
    chk("stream_last_cycle", 64'(last_cyc), 64'd7);
    chk("stream_stalled", 64'(have_held), 64'h1);
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    chk("stream_no_dup", 64'(ex_valid), 64'h0);

    // Flush with a held bundle and an incoming instruction
    if_valid = 1'b1;
    if_inst  = 32'h00900493;  // ADDI x9,x0,9
    ex_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_flush_valid", 64'(ex_valid), 64'h1);
    flush   = 1'b1;
    if_inst = 32'h00A00513;  // ADDI x10,x0,10
    #1;
    chk("flush_if_ready", 64'(if_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("flush_valid", 64'(ex_valid), 64'h0);
    @(negedge clk);
    flush    = 1'b0;
    ex_ready = 1'b1;
    if_inst  = 32'h00B00593;  // ADDI x11,x0,11
    @(posedge clk);
    #1;
    if_valid = 1'b0;
    chk("post_flush_valid", 64'(ex_valid), 64'h1);
    chk("post_flush_rd", 64'(ex_rd), 64'd11);
    chk("post_flush_b", ex_b, 64'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that produces the operand/opcode bundle consumed by the RV64 integer ALU in execute.
- Accepts one fetched instruction per cycle over a valid/ready handshake and decodes the RV64I ALU-class opcodes.
- Reads rs1/rs2 from the register file and registers a, b, word32, aluop, rd and wen toward execute, with stall and flush support.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard the held and incoming instruction (redirect)
- if_valid  in  1  fetch bundle valid
- if_ready  out  1  stage can accept; = !ex_valid || ex_ready, forced 0 while flush
- if_pc  in  64  instruction PC
- if_inst  in  32  instruction word
- rs1_addr  out  5  = if_inst[19:15], combinational
- rs2_addr  out  5  = if_inst[24:20], combinational
- rs1_data  in  64  register file read data, same cycle
- rs2_data  in  64  register file read data, same cycle
- ex_valid  out  1  bundle valid toward execute
- ex_ready  in  1  execute accepts bundle
- ex_a  out  64  ALU operand a
- ex_b  out  64  ALU operand b
- ex_word32  out  1  32-bit (W) operation
- ex_aluop  out  aluop_t  ALU operation
- ex_rd  out  5  destination register
- ex_wen  out  1  register writeback enable
- ex_pc  out  64  PC of the held instruction
- ex_illegal  out  1  opcode is not ALU-class; execute traps or forwards it elsewhere

Behaviour:
- Reset (rst=1 at a clk edge): ex_valid=0; all ex_* payload set to 0 (ex_aluop = encoding 0). rst overrides flush and the handshake.
- Accept: fire = if_valid && if_ready && !flush. On fire, decoded fields and the rs1_data/rs2_data values of that cycle are registered; ex_valid=1 on the next cycle. Latency is one cycle.
- Drain: ex_valid && ex_ready && !fire leads to ex_valid=0 next cycle. A simultaneous drain and fire replaces the payload, giving full throughput.
- Stall: ex_valid && !ex_ready holds the payload and ex_valid stable, and if_ready=0.
- Flush: ex_valid=0 next cycle and nothing is captured that cycle. The payload registers may hold stale values.
- Immediates are sign-extended to 64 bits: I=inst[31:20]; U={inst[31:12],12'b0}.
- LUI: aluop=LUI, a=0, b=immU.
- AUIPC: ADD, a=pc, b=immU.
- JAL/JALR: aluop=JAL, a=pc; execute computes pc+4.
- OP-IMM: a=rs1; b=immI. ADDI maps to ADD; SLTI/SLTIU/XORI/ORI/ANDI map to the same-named op.
- OP-IMM shifts: SLLI/SRLI/SRAI use b=inst[25:20] zero-extended. inst[30] selects SRA.
- OP: a=rs1, b=rs2. funct3 and inst[30] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
- OP-IMM-32 / OP-32: ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW set word32=1, with operands formed as above. W-shift immediate b=inst[24:20].
- Any other opcode, or a reserved funct7/funct6 in OP/OP-IMM (e.g. funct7 not 0x00/0x20): ex_illegal=1, ex_wen=0, aluop=ADD, a=b=0.
- ex_wen = legal && rd!=0 && opcode writes rd (all opcodes above do). ex_rd is always inst[11:7].
- No operand forwarding: hazards on rs1/rs2 are the responsibility of the upstream scoreboard.

Test Plan:
- Reset with if_valid=1, inst 0x00500093 at the edge -> ex_valid=0 and ex_a=ex_b=0 after reset. On release, one cycle later ADDI x1,x0,5 gives aluop=ADD, a=0, b=5, rd=1, wen=1.
- SUB x3,x1,x2 (0x402081B3) with rs1_data=10, rs2_data=3 -> aluop=SUB, a=10, b=3, word32=0, rd=3. Then LUI x5,0x80000 (0x800002B7) -> aluop=LUI, b=0xFFFFFFFF80000000.
- ADDIW x6,x6,-1 (0xFFF3031B) -> word32=1, b=0xFFFFFFFFFFFFFFFF. SRAI x7,x7,63 (0x43F3D393) -> aluop=SRA, b=63.
- Back-to-back stream of 4 instructions with ex_ready=0 for 3 cycles mid-stream -> if_ready=0 and the payload stays stable while stalled. All 4 arrive in order with none dropped or duplicated; with ex_ready=1 throughput is 1/cycle.
- flush asserted while ex_valid=1 and if_valid=1 -> next cycle ex_valid=0 and the incoming instruction is not captured. The next cycle with fire resumes normally.
- Store opcode 0x00112023, and OP with funct7=0x01 -> ex_illegal=1, ex_wen=0. ADDI x0,x0,0 (0x00000013) -> ex_illegal=0, ex_wen=0.
